pll_drp_reconfig: RTL and testbench

//  Run-time clock profile switcher for a PLLE2_ADV, driving the PLL DRP and RST pins.
//  On request it programs one of NUM_PROFILES register sets, e.g. PAL/NTSC Amiga chipset clocks.

---
 rtl/pll_drp_reconfig.sv | 229 ++++++++++++++++++++++
 tb/tb_pll_drp_reconfig.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_drp_reconfig.sv
// -----------------------------------------------------------------------------
// pll_drp_reconfig
//
// Run-time clock profile switcher for a PLLE2_ADV. On request (and once after
// every reset) it holds the PLL in reset, rewrites a set of DRP registers with
// read-modify-write cycles taken from a constant profile table, then releases
// the PLL reset and waits for LOCKED.
//
// Profile table layout: entry k = profile*REGS_PER_PROFILE + reg occupies
// PROFILE_TABLE[39k+38:39k] as {addr[6:0], mask[15:0], data[15:0]}.
// A mask bit of 1 keeps the bit read back from the PLL, 0 takes the table data.
// DRDY_TIMEOUT and LOCK_TIMEOUT must be at least 2, RST_HOLD at least 1.
//
// Ports
//   clk_i            controller / DRP clock (also the PLL DCLK)
//   reset_n_i        synchronous reset, active low
//   profile_sel_i    requested profile, sampled only on an accepted start
//   start_i          one-cycle request to program profile_sel_i
//   busy_o           high from boot / accepted start until done or error
//   done_o           one-cycle pulse: profile programmed and PLL locked
//   error_o          one-cycle pulse: bad profile, DRDY timeout or lock timeout
//   active_profile_o last profile that completed successfully
//   pll_rst_o        PLL RST
//   pll_locked_i     PLL LOCKED, treated as synchronous to clk_i
//   drp_daddr_o      DRP address
//   drp_di_o         DRP write data
//   drp_den_o        DRP enable, one-cycle pulse per access
//   drp_dwe_o        DRP write enable, only together with drp_den_o
//   drp_do_i         DRP read data
//   drp_drdy_i       DRP access complete
// -----------------------------------------------------------------------------
module pll_drp_reconfig #(
  parameter int NUM_PROFILES     = 2,
  parameter int REGS_PER_PROFILE = 8,
  parameter logic [NUM_PROFILES*REGS_PER_PROFILE*39-1:0] PROFILE_TABLE = '0,
  parameter int DEFAULT_PROFILE  = 0,
  parameter int RST_HOLD         = 4,
  parameter int DRDY_TIMEOUT     = 64,
  parameter int LOCK_TIMEOUT     = 65535,
  localparam int PW = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic [PW-1:0] profile_sel_i,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          error_o,
  output logic [PW-1:0] active_profile_o,
  output logic          pll_rst_o,
  input  logic          pll_locked_i,
  output logic [6:0]    drp_daddr_o,
  output logic [15:0]   drp_di_o,
  output logic          drp_den_o,
  output logic          drp_dwe_o,
  input  logic [15:0]   drp_do_i,
  input  logic          drp_drdy_i
);

  localparam int IW      = (REGS_PER_PROFILE > 1) ? $clog2(REGS_PER_PROFILE) : 1;
  localparam int MAX_A   = (RST_HOLD > DRDY_TIMEOUT) ? RST_HOLD : DRDY_TIMEOUT;
  localparam int CNT_MAX = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [PW-1:0] DEFAULT_SEL = PW'(DEFAULT_PROFILE);
  localparam logic [IW-1:0] IDX_LAST    = IW'(REGS_PER_PROFILE - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(RST_HOLD - 1);
  localparam logic [CW-1:0] DRDY_LAST   = CW'(DRDY_TIMEOUT - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, HOLD, RD, RDW, WR, WRW, REL, LOCK} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [PW-1:0]   sel_q, sel_d;
  logic [15:0]     rdData_q, rdData_d;
  logic            pllRst_q, pllRst_d;
  logic [PW-1:0]   active_q, active_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  logic [38:0]     entry;
  logic [6:0]      entryAddr;
  logic [15:0]     entryMask;
  logic [15:0]     entryData;
  logic [15:0]     wrData;

  // Table lookup for the register currently being programmed, and the merged
  // write value: masked bits come from the read-back, the rest from the table.
  always_comb begin
    entry     = 39'(PROFILE_TABLE >> (39 * (int'(sel_q) * REGS_PER_PROFILE + int'(idx_q))));
    entryAddr = entry[38:32];
    entryMask = entry[31:16];
    entryData = entry[15:0];
    wrData    = (rdData_q & entryMask) | (entryData & ~entryMask);
  end

  // State and datapath registers. Reset lands in HOLD with the default profile
  // latched, so boot programming starts as soon as reset_n_i is released.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q  <= HOLD;
      cnt_q    <= '0;
      idx_q    <= '0;
      sel_q    <= DEFAULT_SEL;
      rdData_q <= '0;
      pllRst_q <= 1'b1;
      active_q <= DEFAULT_SEL;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sel_q    <= sel_d;
      rdData_q <= rdData_d;
      pllRst_q <= pllRst_d;
      active_q <= active_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  // Next-state logic. cnt_q is shared: RST hold length in HOLD, cycles since
  // the DRP enable in RDW/WRW, and cycles spent waiting in LOCK. A DRP timeout
  // leaves pll_rst asserted because the PLL registers are now half-written.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    sel_d    = sel_q;
    rdData_d = rdData_q;
    pllRst_d = pllRst_q;
    active_d = active_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (int'(profile_sel_i) < NUM_PROFILES) begin
            sel_d    = profile_sel_i;
            idx_d    = '0;
            cnt_d    = '0;
            pllRst_d = 1'b1;
            state_d  = HOLD;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (cnt_q >= HOLD_LAST) begin
          cnt_d   = '0;
          state_d = RD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RD: begin
        cnt_d   = CW'(1);
        state_d = RDW;
      end
      RDW: begin
        if (drp_drdy_i) begin
          rdData_d = drp_do_i;
          state_d  = WR;
        end else if (cnt_q >= DRDY_LAST) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WR: begin
        cnt_d   = CW'(1);
        state_d = WRW;
      end
      WRW: begin
        if (drp_drdy_i) begin
          if (idx_q == IDX_LAST) begin
            pllRst_d = 1'b0;
            state_d  = REL;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = RD;
          end
        end else if (cnt_q >= DRDY_LAST) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      REL: begin
        cnt_d   = '0;
        state_d = LOCK;
      end
      LOCK: begin
        if (pll_locked_i) begin
          active_d = sel_q;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else if (cnt_q >= LOCK_LAST) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs. DRP address and data are only driven during the enable cycle so
  // the bus idles at zero between accesses.
  always_comb begin
    busy_o           = (state_q != IDLE);
    done_o           = done_q;
    error_o          = error_q;
    active_profile_o = active_q;
    pll_rst_o        = pllRst_q;
    drp_den_o        = (state_q == RD) || (state_q == WR);
    drp_dwe_o        = (state_q == WR);
    drp_daddr_o      = drp_den_o ? entryAddr : 7'd0;
    drp_di_o         = (state_q == WR) ? wrData : 16'd0;
  end

endmodule

// File: tb/tb_pll_drp_reconfig.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// Testbench for pll_drp_reconfig.
// The DUT runs with three profiles so that an out-of-range select (3) exists
// on the 2-bit profile_sel port. A behavioural DRP slave answers every access
// with a one-cycle drdy and logs it; a PLL model raises LOCKED ten cycles
// after RST falls.
// -----------------------------------------------------------------------------
module tb_pll_drp_reconfig;

  localparam int NP       = 3;
  localparam int NR       = 8;
  localparam int TBL_W    = NP * NR * 39;
  localparam int RST_HOLD = 4;
  localparam int DRDY_TO  = 8;
  localparam int LOCK_TO  = 40;

  // Profile p register r lives at address 0x08 + 16p + r.
  function automatic logic [38:0] getEntry(input int p, input int r);
    logic [6:0]  a;
    logic [15:0] m;
    logic [15:0] d;
    a = 7'(8 + 16 * p + r);
    if (p == 0 && r == 0) begin
      m = 16'h1000;
      d = 16'h0041;
    end else begin
      m = 16'(32'h00FF << r);
      d = 16'(32'h1234 * (p + 1) + 32'h0101 * r);
    end
    return {a, m, d};
  endfunction

  function automatic logic [TBL_W-1:0] buildTable();
    logic [TBL_W-1:0] t;
    t = '0;
    for (int p = 0; p < NP; p++)
      for (int r = 0; r < NR; r++)
        t = t | (TBL_W'(getEntry(p, r)) << ((p * NR + r) * 39));
    return t;
  endfunction

  // Power-on contents of the modelled PLL registers.
  function automatic logic [15:0] initMem(input logic [6:0] a);
    return (a == 7'h08) ? 16'hFFFF : (16'h5A00 | 16'(a));
  endfunction

  localparam logic [TBL_W-1:0] TABLE = buildTable();

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  profile_sel = 2'd0;
  logic        busy, done, error;
  logic [1:0]  active;
  logic        pll_rst;
  logic        pll_locked = 1'b0;
  logic [6:0]  daddr;
  logic [15:0] di;
  logic        den, dwe;
  logic [15:0] drp_do = 16'd0;
  logic        drdy = 1'b0;

  pll_drp_reconfig #(
    .NUM_PROFILES(NP),
    .REGS_PER_PROFILE(NR),
    .PROFILE_TABLE(TABLE),
    .DEFAULT_PROFILE(0),
    .RST_HOLD(RST_HOLD),
    .DRDY_TIMEOUT(DRDY_TO),
    .LOCK_TIMEOUT(LOCK_TO)
  ) dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .profile_sel_i(profile_sel),
    .start_i(start),
    .busy_o(busy),
    .done_o(done),
    .error_o(error),
    .active_profile_o(active),
    .pll_rst_o(pll_rst),
    .pll_locked_i(pll_locked),
    .drp_daddr_o(daddr),
    .drp_di_o(di),
    .drp_den_o(den),
    .drp_dwe_o(dwe),
    .drp_do_i(drp_do),
    .drp_drdy_i(drdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  addr;
    logic        we;
    logic [15:0] di;
    int          cyc;
    int          rstRun;
  } drpAccess_t;

  drpAccess_t  drpLog[$];
  logic [15:0] mem[128];
  bit          written[128];
  bit          drdyEnable = 1'b1;
  bit          lockEnable = 1'b1;
  int          cycleCnt = 0;
  int          errCycle = 0;
  int          rstFallCycle = 0;
  int          rstRun = 0;
  int          lockCnt = 0;
  logic        prevRst = 1'b1;

  // DRP slave plus timestamps: rstRun is how many cycles RST has been high
  // in a row, captured into each logged access.
  always @(posedge clk) begin
    cycleCnt <= cycleCnt + 1;
    prevRst  <= pll_rst;
    rstRun   <= pll_rst ? rstRun + 1 : 0;
    if (!pll_rst && prevRst) rstFallCycle <= cycleCnt;
    if (error) errCycle <= cycleCnt;
    drdy <= 1'b0;
    if (den) begin
      drpLog.push_back('{daddr, dwe, di, cycleCnt, rstRun});
      if (drdyEnable) drdy <= 1'b1;
      if (dwe) begin
        mem[daddr]     <= di;
        written[daddr] <= 1'b1;
      end else begin
        drp_do <= written[daddr] ? mem[daddr] : initMem(daddr);
      end
    end
  end

  // PLL lock model: LOCKED rises ten cycles after RST falls.
  always @(posedge clk) begin
    if (pll_rst || !lockEnable) begin
      lockCnt    <= 0;
      pll_locked <= 1'b0;
    end else if (lockCnt >= 9) begin
      pll_locked <= 1'b1;
    end else begin
      lockCnt <= lockCnt + 1;
    end
  end

  int testsRun = 0;
  int failed = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] sel);
    @(negedge clk);
    start       = 1'b1;
    profile_sel = sel;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitResult(input int bound, output logic gotDone,
                            output logic gotErr, output int waited);
    waited = 0;
    while (!done && !error && waited < bound) begin
      @(negedge clk);
      waited++;
    end
    gotDone = done;
    gotErr  = error;
  endtask

  typedef struct {
    logic [1:0] sel;
    logic       expDone;
    logic       expErr;
    logic [1:0] expActive;
    int         expDens;
    int         expWait;
  } vector_t;

  vector_t vectors[4];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, failed=%0d", failed);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic        gotDone, gotErr;
    int          waited, base, writes;
    logic [38:0] e;
    logic [15:0] expDi;

    // sel, done, error, active after, DRP accesses, wait (-1 = not checked)
    vectors[0] = '{2'd1, 1'b1, 1'b0, 2'd1, 16, -1};
    vectors[1] = '{2'd3, 1'b0, 1'b1, 2'd1, 0, 0};
    vectors[2] = '{2'd0, 1'b1, 1'b0, 2'd0, 16, -1};
    vectors[3] = '{2'd2, 1'b1, 1'b0, 2'd2, 16, -1};

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rstPllRst", 32'(pll_rst), 32'd1);
    checkOutput("rstBusy", 32'(busy), 32'd1);
    checkOutput("rstDoneErr", 32'({done, error}), 32'd0);
    checkOutput("rstDenDwe", 32'({den, dwe}), 32'd0);
    checkOutput("rstDaddr", 32'(daddr), 32'd0);
    checkOutput("rstDi", 32'(di), 32'd0);
    checkOutput("rstActive", 32'(active), 32'd0);

    // Boot programming of profile 0
    base = drpLog.size();
    reset_n = 1'b1;
    waitResult(400, gotDone, gotErr, waited);
    checkOutput("bootDone", 32'(gotDone), 32'd1);
    checkOutput("bootError", 32'(gotErr), 32'd0);
    checkOutput("bootActive", 32'(active), 32'd0);
    checkOutput("bootBusy", 32'(busy), 32'd0);
    checkOutput("bootPllRst", 32'(pll_rst), 32'd0);
    checkOutput("bootCount", 32'(drpLog.size() - base), 32'd16);
    for (int r = 0; r < NR && base + 2 * r + 1 < drpLog.size(); r++) begin
      e = getEntry(0, r);
      expDi = (initMem(e[38:32]) & e[31:16]) | (e[15:0] & ~e[31:16]);
      checkOutput("bootRead", 32'({drpLog[base + 2 * r].we, drpLog[base + 2 * r].addr}),
                  32'({1'b0, e[38:32]}));
      checkOutput("bootWrite", 32'({drpLog[base + 2 * r + 1].we, drpLog[base + 2 * r + 1].addr}),
                  32'({1'b1, e[38:32]}));
      checkOutput("bootWrData", 32'(drpLog[base + 2 * r + 1].di), 32'(expDi));
    end
    if (drpLog.size() > base + 1)
      checkOutput("rmwReg08", 32'(drpLog[base + 1].di), 32'h1041);

    // Table-driven profile requests
    for (int v = 0; v < 4; v++) begin
      base = drpLog.size();
      applyStimulus(vectors[v].sel);
      waitResult(400, gotDone, gotErr, waited);
      checkOutput("vecDone", 32'(gotDone), 32'(vectors[v].expDone));
      checkOutput("vecError", 32'(gotErr), 32'(vectors[v].expErr));
      if (vectors[v].expWait >= 0)
        checkOutput("vecLatency", 32'(waited), 32'(vectors[v].expWait));
      @(negedge clk);
      checkOutput("vecPulseClear", 32'({done, error}), 32'd0);
      checkOutput("vecActive", 32'(active), 32'(vectors[v].expActive));
      checkOutput("vecBusy", 32'(busy), 32'd0);
      checkOutput("vecPllRst", 32'(pll_rst), 32'd0);
      checkOutput("vecDenCount", 32'(drpLog.size() - base), 32'(vectors[v].expDens));
      if (drpLog.size() > base) begin
        e = getEntry(int'(vectors[v].sel), 0);
        checkOutput("vecFirstAddr", 32'({drpLog[base].we, drpLog[base].addr}),
                    32'({1'b0, e[38:32]}));
        checkOutput("vecRstHold", 32'(drpLog[base].rstRun >= RST_HOLD), 32'd1);
      end
    end

    // Start while busy is dropped, not queued
    base = drpLog.size();
    applyStimulus(2'd1);
    repeat (10) @(negedge clk);
    applyStimulus(2'd2);
    waitResult(400, gotDone, gotErr, waited);
    checkOutput("busyStartDone", 32'(gotDone), 32'd1);
    checkOutput("busyStartActive", 32'(active), 32'd1);
    checkOutput("busyStartCount", 32'(drpLog.size() - base), 32'd16);
    if (drpLog.size() >= base + 16) begin
      e = getEntry(1, NR - 1);
      checkOutput("busyStartLastAddr", 32'(drpLog[base + 15].addr), 32'(e[38:32]));
    end
    repeat (5) @(negedge clk);
    checkOutput("busyStartNotQueued", 32'({busy, 5'(drpLog.size() - base)}), 32'({1'b0, 5'd16}));

    // LOCKED dropping while idle
    lockEnable = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("lockDropIdle", 32'({busy, done, error, pll_rst}), 32'd0);
    checkOutput("lockDropActive", 32'(active), 32'd1);
    lockEnable = 1'b1;

    // DRDY never arrives
    drdyEnable = 1'b0;
    base = drpLog.size();
    applyStimulus(2'd2);
    waitResult(100, gotDone, gotErr, waited);
    checkOutput("drdyToError", 32'(gotErr), 32'd1);
    checkOutput("drdyToDone", 32'(gotDone), 32'd0);
    checkOutput("drdyToPllRst", 32'(pll_rst), 32'd1);
    @(negedge clk);
    checkOutput("drdyToCount", 32'(drpLog.size() - base), 32'd1);
    if (drpLog.size() > base)
      checkOutput("drdyToCycles", 32'(errCycle - drpLog[base].cyc), 32'(DRDY_TO));
    checkOutput("drdyToActive", 32'(active), 32'd1);
    checkOutput("drdyToBusy", 32'(busy), 32'd0);
    drdyEnable = 1'b1;

    // Reset during the third write reboots profile 0
    applyStimulus(2'd2);
    writes = 0;
    for (int i = 0; i < 300 && writes < 3; i++) begin
      @(negedge clk);
      if (den && dwe) writes++;
    end
    checkOutput("abortReached", 32'(writes), 32'd3);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("abortPllRst", 32'(pll_rst), 32'd1);
    checkOutput("abortBusy", 32'(busy), 32'd1);
    checkOutput("abortDen", 32'(den), 32'd0);
    checkOutput("abortActive", 32'(active), 32'd0);
    base = drpLog.size();
    reset_n = 1'b1;
    waitResult(400, gotDone, gotErr, waited);
    checkOutput("rebootDone", 32'(gotDone), 32'd1);
    checkOutput("rebootActive", 32'(active), 32'd0);
    checkOutput("rebootCount", 32'(drpLog.size() - base), 32'd16);
    if (drpLog.size() > base)
      checkOutput("rebootFirst", 32'({drpLog[base].we, drpLog[base].addr}), 32'({1'b0, 7'h08}));

    // LOCKED never arrives: REL takes one cycle, then LOCK waits LOCK_TO cycles
    lockEnable = 1'b0;
    applyStimulus(2'd1);
    waitResult(300, gotDone, gotErr, waited);
    checkOutput("lockToError", 32'(gotErr), 32'd1);
    checkOutput("lockToDone", 32'(gotDone), 32'd0);
    checkOutput("lockToPllRst", 32'(pll_rst), 32'd0);
    @(negedge clk);
    checkOutput("lockToCycles", 32'(errCycle - rstFallCycle), 32'(LOCK_TO + 1));
    checkOutput("lockToActive", 32'(active), 32'd0);
    lockEnable = 1'b1;

    $display("[TB] %0d tests run, %0d failed", testsRun, failed);
    $finish;
  end

endmodule
